// File: rtl/uart_tx_arbiter.sv
// Round-robin sharer of one UART byte serializer between NUM_REQ requesters.
// Optional burst locking: define UART_TX_ARB_BURST_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         ser_start,
  output logic [DATA_BITS-1:0]         ser_data,
  input  logic                         ser_done,
  output logic                         busy,
  output logic [GW-1:0]                grant_id,
  output logic                         timeout_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] PTR_RST = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        gid_q, gid_d;
  logic [NUM_REQ-1:0]   rdy_q, rdy_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [WW-1:0]        wd_q, wd_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [GW-1:0]        win;
  logic                 sel_valid;
  logic [DATA_BITS-1:0] sel_data;
  logic                 wd_fire;

  assign wd_fire = (state_q == S_WAIT) && !ser_done && (wd_q == WD_MAX);

`ifdef UART_TX_ARB_BURST_EN
  logic lock_q, lock_d;
  logic sel_last;

  // Select the end-of-burst flag of the requester currently granted.
  always_comb begin
    sel_last = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ptr_q == GW'(j)) sel_last = req_last[j];
    end
  end

  // Lock follows the last flag of each accepted byte; watchdog drops it.
  always_comb begin
    lock_d = lock_q;
    if (state_q == S_GRANT && sel_valid) begin
      lock_d = !sel_last;
    end else if (wd_fire) begin
      lock_d = 1'b0;
    end
  end

  // Burst lock register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end

  // While locked only the owning requester is eligible.
  always_comb begin
    cand = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand[j] = req_valid[j] && (!lock_q || ptr_q == GW'(j));
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  // Every valid requester competes for every byte.
  always_comb begin
    cand = req_valid;
  end
`endif

  // Round-robin pick: first candidate above the pointer, then wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && cand[j] && GW'(j) > ptr_q) begin
        found = 1'b1;
        win   = GW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && cand[j] && GW'(j) <= ptr_q) begin
        found = 1'b1;
        win   = GW'(j);
      end
    end
  end

  // Mux valid and data of the granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ptr_q == GW'(j)) begin
        sel_valid = req_valid[j];
        sel_data  = req_data[j*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    rdy_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ptr_d   = win;
          gid_d   = win;
          state_d = S_GRANT;
          for (int j = 0; j < NUM_REQ; j++) begin
            rdy_d[j] = (win == GW'(j));
          end
        end
      end
      S_GRANT: begin
        if (sel_valid) begin
          data_d  = sel_data;
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ser_done) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      gid_q   <= '0;
      rdy_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
    end
  end

  assign req_ready   = rdy_q;
  assign ser_start   = start_q;
  assign ser_data    = data_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small serializer model.
// Expected values are hand-derived from the cycle behaviour.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        ser_start;
  logic [7:0]  ser_data;
  logic        ser_done;
  logic        busy;
  logic [0:0]  grant_id;
  logic        timeout_err;

  logic        done_en;
  logic        force_done;
  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [7:0]  m_sh;
  logic        m_line;
  logic        mdl_done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk),
    .reset(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .ser_start(ser_start),
    .ser_data(ser_data),
    .ser_done(ser_done),
    .busy(busy),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  // Serializer model: start bit, 8 data LSB first, stop, done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_sh   <= '0;
    end else if (!m_busy) begin
      if (ser_start) begin
        m_busy <= 1'b1;
        m_cnt  <= '0;
        m_sh   <= ser_data;
      end
    end else if (m_cnt == 4'd10) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  always_comb begin
    if (!m_busy)              m_line = 1'b1;
    else if (m_cnt == 4'd0)   m_line = 1'b0;
    else if (m_cnt <= 4'd8)   m_line = m_sh[3'(m_cnt - 4'd1)];
    else                      m_line = 1'b1;
  end

  assign mdl_done = m_busy && (m_cnt == 4'd10) && done_en;
  assign ser_done = mdl_done | force_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!ser_start && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(ser_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  logic [9:0] line_bits;
  int         t_st [4];
  logic [7:0] d_st [4];
  logic [0:0] g_st [4];
  int         ng;
  int         c1;
  logic       x1;
  int         eg [4];

  initial begin
    #100000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    done_en    = 1'b1;
    force_done = 1'b0;
    rst_n      = 1'b0;
    tick(2);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(ser_start), 32'd0);
    chk("rst_data",  32'(ser_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_gid",   32'(grant_id), 32'd0);
    chk("rst_err",   32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Done in IDLE is ignored.
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'd0);

    // Single byte 0xA5 from requester 0.
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    tick(1);
    chk("t1_ready",   32'(req_ready), 32'd1);
    chk("t1_nostart", 32'(ser_start), 32'd0);
    chk("t1_busy",    32'(busy), 32'd1);
    tick(1);
    chk("t1_start",   32'(ser_start), 32'd1);
    chk("t1_data",    32'(ser_data), 32'hA5);
    chk("t1_rdy_off", 32'(req_ready), 32'd0);
    chk("t1_gid",     32'(grant_id), 32'd0);
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      line_bits[i] = m_line;
    end
    chk("t1_line", 32'(line_bits), 32'(10'b1101001010));
    tick(1);
    chk("t1_busy_done", 32'(busy), 32'd1);
    tick(1);
    chk("t1_busy_fall", 32'(busy), 32'd0);

    // Contention: both valid, strict alternation, 14-cycle period.
    do_reset();
    req_valid = 2'b11;
    req_data  = 16'h2211;
    ng = 0;
    for (int t = 0; t < 100 && ng < 4; t++) begin
      tick(1);
      if (ser_start) begin
        t_st[ng] = t;
        d_st[ng] = ser_data;
        g_st[ng] = grant_id;
        ng++;
      end
    end
    req_valid = 2'b00;
    chk("t2_count", 32'(ng), 32'd4);
    chk("t2_g0", 32'(g_st[0]), 32'd0);
    chk("t2_g1", 32'(g_st[1]), 32'd1);
    chk("t2_g2", 32'(g_st[2]), 32'd0);
    chk("t2_g3", 32'(g_st[3]), 32'd1);
    chk("t2_d0", 32'(d_st[0]), 32'h11);
    chk("t2_d1", 32'(d_st[1]), 32'h22);
    chk("t2_d2", 32'(d_st[2]), 32'h11);
    chk("t2_d3", 32'(d_st[3]), 32'h22);
    chk("t2_p1", 32'(t_st[1] - t_st[0]), 32'd14);
    chk("t2_p2", 32'(t_st[2] - t_st[1]), 32'd14);
    chk("t2_p3", 32'(t_st[3] - t_st[2]), 32'd14);
    wait_idle("t2_idle");

    // Watchdog: serializer never reports done.
    done_en   = 1'b0;
    req_valid = 2'b01;
    req_data  = 16'h003C;
    wait_start("t3_start");
    req_valid = 2'b00;
    tick(64);
    chk("t3_err_early", 32'(timeout_err), 32'd0);
    chk("t3_busy_wait", 32'(busy), 32'd1);
    tick(1);
    chk("t3_err", 32'(timeout_err), 32'd1);
    chk("t3_busy_off", 32'(busy), 32'd0);
    done_en   = 1'b1;
    req_valid = 2'b10;
    req_data  = 16'h5A00;
    wait_start("t3_rec_start");
    chk("t3_rec_gid",  32'(grant_id), 32'd1);
    chk("t3_rec_data", 32'(ser_data), 32'h5A);
    chk("t3_sticky",   32'(timeout_err), 32'd1);
    req_valid = 2'b00;
    wait_idle("t3_idle");

    // Reset mid-byte.
    req_valid = 2'b10;
    req_data  = 16'h7700;
    wait_start("t4_start");
    req_valid = 2'b00;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_ready", 32'(req_ready), 32'd0);
    chk("t4_start", 32'(ser_start), 32'd0);
    chk("t4_data",  32'(ser_data), 32'd0);
    chk("t4_busy",  32'(busy), 32'd0);
    chk("t4_gid",   32'(grant_id), 32'd0);
    chk("t4_err",   32'(timeout_err), 32'd0);
    tick(1);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_data  = 16'h4281;
    wait_start("t4_re_start");
    chk("t4_re_gid",  32'(grant_id), 32'd0);
    chk("t4_re_data", 32'(ser_data), 32'h81);
    req_valid = 2'b00;
    wait_idle("t4_idle");

    // Valid drop in GRANT: no start, pointer still moves.
    req_valid = 2'b10;
    req_data  = 16'h9933;
    tick(1);
    chk("t5_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    tick(1);
    chk("t5_nostart", 32'(ser_start), 32'd0);
    chk("t5_idle",    32'(busy), 32'd0);
    req_valid = 2'b11;
    tick(1);
    chk("t5_gid",   32'(grant_id), 32'd0);
    chk("t5_rdy0",  32'(req_ready), 32'd1);
    tick(1);
    chk("t5_start", 32'(ser_start), 32'd1);
    chk("t5_data",  32'(ser_data), 32'h33);
    req_valid  = 2'b00;
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    chk("t5_done_in_start", 32'(busy), 32'd1);
    wait_idle("t5_idle2");

    // Burst: req1 sends last=0,0,1 while req0 stays valid.
`ifdef UART_TX_ARB_BURST_EN
    eg[0] = 1; eg[1] = 1; eg[2] = 1; eg[3] = 0;
`else
    eg[0] = 1; eg[1] = 0; eg[2] = 1; eg[3] = 0;
`endif
    req_valid = 2'b11;
    req_data  = 16'hD1C0;
    req_last  = 2'b01;
    ng = 0;
    c1 = 0;
    for (int t = 0; t < 200 && ng < 4; t++) begin
      if (ser_start) begin
        g_st[ng] = grant_id;
        ng++;
      end
      x1 = req_ready[1] && req_valid[1];
      tick(1);
      if (x1) begin
        c1++;
        if (c1 == 2) req_last[1] = 1'b1;
        if (c1 == 3) req_valid[1] = 1'b0;
      end
    end
    req_valid = 2'b00;
    chk("t6_count", 32'(ng), 32'd4);
    chk("t6_g0", 32'(g_st[0]), 32'(eg[0]));
    chk("t6_g1", 32'(g_st[1]), 32'(eg[1]));
    chk("t6_g2", 32'(g_st[2]), 32'(eg[2]));
    chk("t6_g3", 32'(g_st[3]), 32'(eg[3]));
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
